uart_rx: RTL

//   UART receiver; consumer of the baud generator's rxclk_en (one pulse per
//   1/SAMPLE_MULTIPLIER bit time). Synchronises the async rx line, detects

---
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop rx synchroniser, oversampled start/data/stop framing, valid/ready byte output.
// Optional parity stage enabled by defining UART_RX_PARITY_EN (adds parameter PARITY_ODD).
module uart_rx #(
    parameter int SAMPLE_MULTIPLIER = 16,
    parameter int DATA_BITS         = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD        = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxclk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int SCNT_W = $clog2(SAMPLE_MULTIPLIER);
    localparam int BCNT_W = $clog2(DATA_BITS + 1);
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(SAMPLE_MULTIPLIER / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_END  = SCNT_W'(SAMPLE_MULTIPLIER - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_n;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [SCNT_W-1:0]    scnt, scnt_n;
    logic [BCNT_W-1:0]    bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 load;
    logic                 slot_free;
    logic                 par_bad;
    logic                 frame_err_n, overrun_n, parity_err_n;

    assign rx_s = sync[1];

    // A byte may load when the output slot is empty or being emptied this very cycle.
    assign slot_free = !dout_valid || dout_ready;

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_n;
    assign par_bad = ((^shift) ^ par_bit) != PARITY_ODD;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= 2'b11;
            state      <= S_IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            shift      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            sync       <= {sync[0], rx};
            state      <= state_n;
            scnt       <= scnt_n;
            bcnt       <= bcnt_n;
            shift      <= shift_n;
            frame_err  <= frame_err_n;
            overrun    <= overrun_n;
            parity_err <= parity_err_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
`endif
            if (load) begin
                dout       <= shift;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

    // Framing FSM; everything advances only on oversample ticks.
    always_comb begin
        state_n      = state;
        scnt_n       = scnt;
        bcnt_n       = bcnt;
        shift_n      = shift;
        load         = 1'b0;
        frame_err_n  = 1'b0;
        overrun_n    = 1'b0;
        parity_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n    = par_bit;
`endif
        if (rxclk_en) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n = S_START;
                        scnt_n  = '0;
                    end
                end
                S_START: begin
                    if (scnt == SCNT_MID) begin
                        scnt_n  = '0;
                        bcnt_n  = '0;
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (scnt == SCNT_END) begin
                        scnt_n  = '0;
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        if (bcnt == BCNT_LAST) begin
                            bcnt_n  = '0;
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end else begin
                            bcnt_n = bcnt + BCNT_W'(1);
                        end
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (scnt == SCNT_END) begin
                        scnt_n    = '0;
                        par_bit_n = rx_s;
                        state_n   = S_STOP;
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (scnt == SCNT_END) begin
                        scnt_n = '0;
                        if (!rx_s) begin
                            frame_err_n  = 1'b1;
                            parity_err_n = par_bad;
                            state_n      = S_BREAK;
                        end else begin
                            state_n = S_IDLE;
                            if (par_bad) begin
                                parity_err_n = 1'b1;
                            end else if (slot_free) begin
                                load = 1'b1;
                            end else begin
                                overrun_n = 1'b1;
                            end
                        end
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new start bit counts.
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule
